// File: rtl/hwag_reg_sched.sv
// hwag register RAM scheduler: boot-table copy, then host/core round-robin access.
// Optional boot copy is built only when HWAG_REG_BOOT_EN is defined.
module hwag_reg_sched #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int RAM_DEPTH = 131
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] boot_addr,
    input  logic [DATA_W-1:0] boot_data,
    output logic              boot_done,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_ack,
    output logic [DATA_W-1:0] h_rdata,
    input  logic              c_req,
    input  logic [ADDR_W-1:0] c_addr,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
`ifdef HWAG_REG_BOOT_EN
        S_BOOT = 2'd0,
`endif
        S_ARB  = 2'd1,
        S_ACC  = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(RAM_DEPTH);

`ifdef HWAG_REG_BOOT_EN
    localparam state_t LP_INIT = S_BOOT;
    localparam logic   LP_DONE = 1'b0;
`else
    localparam state_t LP_INIT = S_ARB;
    localparam logic   LP_DONE = 1'b1;
`endif

    state_t            r_state;
    logic              r_last_c;
    logic              r_win_h;
    logic              r_wr;
    logic              r_live;
    logic              r_boot_done;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_ram_we;
    logic              r_ram_re;
    logic              r_h_ack;
    logic              r_c_ack;
    logic [DATA_W-1:0] r_h_rdata;
    logic [DATA_W-1:0] r_c_rdata;

    logic              w_pick_h;
    logic [ADDR_W-1:0] w_addr;
    logic              w_we;
    logic              w_inr;

    // On contention the requester that was not served last wins
    assign w_pick_h = h_req & (~c_req | r_last_c);
    assign w_addr   = w_pick_h ? h_addr : c_addr;
    assign w_we     = w_pick_h & h_we;
    assign w_inr    = {1'b0, w_addr} < LP_DEPTH;

`ifdef HWAG_REG_BOOT_EN
    logic [ADDR_W:0] r_bcnt;
    logic            w_bmore;

    assign w_bmore   = r_bcnt < LP_DEPTH;
    assign boot_addr = r_bcnt[ADDR_W-1:0];
    // Boot writes take the registered ROM word straight through
    assign ram_wdata = (r_state == S_BOOT && r_ram_we) ? boot_data
                                                       : r_ram_wdata;
`else
    logic w_unused_boot;

    assign w_unused_boot = ^boot_data;
    assign boot_addr     = '0;
    assign ram_wdata     = r_ram_wdata;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= LP_INIT;
            r_last_c    <= 1'b1;
            r_win_h     <= 1'b0;
            r_wr        <= 1'b0;
            r_live      <= 1'b0;
            r_boot_done <= LP_DONE;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_we    <= 1'b0;
            r_ram_re    <= 1'b0;
            r_h_ack     <= 1'b0;
            r_c_ack     <= 1'b0;
            r_h_rdata   <= '0;
            r_c_rdata   <= '0;
`ifdef HWAG_REG_BOOT_EN
            r_bcnt      <= '0;
`endif
        end else begin
            unique case (r_state)
`ifdef HWAG_REG_BOOT_EN
                S_BOOT: begin
                    if (w_bmore) begin
                        r_ram_we   <= 1'b1;
                        r_ram_addr <= r_bcnt[ADDR_W-1:0];
                        r_bcnt     <= r_bcnt + 1'b1;
                    end else begin
                        r_ram_we    <= 1'b0;
                        r_bcnt      <= '0;
                        r_boot_done <= 1'b1;
                        r_state     <= S_ARB;
                    end
                end
`endif
                S_ARB: begin
                    if (h_req | c_req) begin
                        r_win_h    <= w_pick_h;
                        r_wr       <= w_we;
                        r_live     <= ~w_we & w_inr;
                        r_ram_addr <= w_addr;
                        if (w_we)
                            r_ram_wdata <= h_wdata;
                        r_ram_we   <= w_we & w_inr;
                        r_ram_re   <= ~w_we & w_inr;
                        r_state    <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_ram_we <= 1'b0;
                    r_ram_re <= 1'b0;
                    r_h_ack  <= r_win_h;
                    r_c_ack  <= ~r_win_h;
                    r_last_c <= ~r_win_h;
                    // Out-of-range reads return zero with normal latency
                    if (!r_wr && !r_live) begin
                        if (r_win_h)
                            r_h_rdata <= '0;
                        else
                            r_c_rdata <= '0;
                    end
                    r_state  <= S_RSP;
                end
                S_RSP: begin
                    r_h_ack <= 1'b0;
                    r_c_ack <= 1'b0;
                    if (r_live) begin
                        if (r_win_h)
                            r_h_rdata <= ram_rdata;
                        else
                            r_c_rdata <= ram_rdata;
                    end
                    r_state <= S_ARB;
                end
                default: r_state <= S_ARB;
            endcase
        end
    end

    // RAM data arrives during the ack cycle and is held afterwards
    assign h_rdata   = (r_h_ack && r_live) ? ram_rdata : r_h_rdata;
    assign c_rdata   = (r_c_ack && r_live) ? ram_rdata : r_c_rdata;
    assign h_ack     = r_h_ack;
    assign c_ack     = r_c_ack;
    assign boot_done = r_boot_done;
    assign ram_addr  = r_ram_addr;
    assign ram_we    = r_ram_we;
    assign ram_re    = r_ram_re;

endmodule

// File: tb/tb_hwag_reg_sched.sv
// Directed bench for hwag_reg_sched with ROM and RAM models.
module tb_hwag_reg_sched;

    logic        clk;
    logic        rst;
    logic [7:0]  boot_addr;
    logic [15:0] boot_data;
    logic        boot_done;
    logic        h_req, h_we;
    logic [7:0]  h_addr;
    logic [15:0] h_wdata;
    logic        h_ack;
    logic [15:0] h_rdata;
    logic        c_req;
    logic [7:0]  c_addr;
    logic        c_ack;
    logic [15:0] c_rdata;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we, ram_re;
    logic [15:0] ram_rdata;

    logic [15:0] mem [0:255];
    int errors = 0;
    int checks = 0;

`ifdef HWAG_REG_BOOT_EN
    localparam logic BOOTV = 1'b0;
`else
    localparam logic BOOTV = 1'b1;
`endif

    hwag_reg_sched #(.ADDR_W(8), .DATA_W(16), .RAM_DEPTH(131)) dut (
        .clk(clk), .rst(rst),
        .boot_addr(boot_addr), .boot_data(boot_data), .boot_done(boot_done),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_ack(h_ack), .h_rdata(h_rdata),
        .c_req(c_req), .c_addr(c_addr), .c_ack(c_ack), .c_rdata(c_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial boot_data = '0;
    always @(posedge clk) boot_data <= {8'h00, boot_addr} ^ 16'h5A5A;

    initial begin
        ram_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i) ^ 16'h5A5A;
        forever begin
            @(posedge clk);
            if (ram_we) mem[ram_addr] <= ram_wdata;
            if (ram_re) ram_rdata <= mem[ram_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({ram_we, ram_re, ram_addr, ram_wdata, boot_addr,
             h_ack, c_ack, h_rdata, c_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ram_we=%b ram_re=%b addr=%0d ack=%b%b, want all 0",
                     ram_we, ram_re, ram_addr, h_ack, c_ack);
        end
        checks++;
        if (boot_done !== BOOTV) begin
            errors++;
            $display("FAIL reset_boot_done: got %b want %b", boot_done, BOOTV);
        end
        rst = 1'b1;
        checks++;
        if (boot_done !== BOOTV) begin
            errors++;
            $display("FAIL release_boot_done: got %b want %b", boot_done, BOOTV);
        end
    endtask

    task automatic test_boot;
        int nwe, nbad, nack, done_at;
        nwe = 0; nbad = 0; nack = 0; done_at = -1;
        checks++;
        if (boot_addr !== 8'd0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL boot_cycle0: boot_addr=%0d ram_we=%b want 0/0", boot_addr, ram_we);
        end
        for (int k = 1; k <= 140 && done_at < 0; k++) begin
            @(negedge clk);
            if (k <= 130 && boot_addr !== 8'(k)) nbad++;
            if (ram_we) begin
                if (ram_addr !== 8'(nwe) || ram_wdata !== (16'(nwe) ^ 16'h5A5A)) nbad++;
                nwe++;
            end
            if (h_ack || c_ack) nack++;
            if (boot_done) done_at = k;
        end
        checks++;
        if (nwe != 131) begin
            errors++;
            $display("FAIL boot_writes: got %0d want 131", nwe);
        end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL boot_data: %0d bad cycles want 0", nbad);
        end
        checks++;
        if (nack != 0) begin
            errors++;
            $display("FAIL boot_acks: %0d acks during boot want 0", nack);
        end
        checks++;
        if (done_at != 132) begin
            errors++;
            $display("FAIL boot_done_cycle: got %0d want 132", done_at);
        end
    endtask

    task automatic test_contention;
        int cnt, ovl;
        logic exp_h;
        cnt = 0; ovl = 0;
        @(negedge clk);
        h_req = 1'b1; h_we = 1'b0; h_addr = 8'd10;
        c_req = 1'b1; c_addr = 8'd20;
        for (int t = 1; t <= 20 && cnt < 4; t++) begin
            @(negedge clk);
            if ((h_ack && c_ack) || (ram_we && ram_re)) ovl++;
            if (h_ack || c_ack) begin
                exp_h = (cnt % 2) == 0;
                checks++;
                if (t != 2 + 3 * cnt || h_ack !== exp_h) begin
                    errors++;
                    $display("FAIL rr_grant%0d: t=%0d h_ack=%b want t=%0d h_ack=%b",
                             cnt, t, h_ack, 2 + 3 * cnt, exp_h);
                end
                checks++;
                if (exp_h ? (h_rdata !== 16'h5A50) : (c_rdata !== 16'h5A4E)) begin
                    errors++;
                    $display("FAIL rr_data%0d: h=%h c=%h want h=5a50 c=5a4e",
                             cnt, h_rdata, c_rdata);
                end
                cnt++;
            end
        end
        h_req = 1'b0; c_req = 1'b0;
        checks++;
        if (cnt != 4 || ovl != 0) begin
            errors++;
            $display("FAIL rr_total: acks=%0d overlaps=%0d want 4/0", cnt, ovl);
        end
    endtask

    task automatic test_write_read;
        @(negedge clk);
        h_req = 1'b1; h_we = 1'b1; h_addr = 8'd127; h_wdata = 16'd1024;
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b1 || ram_re !== 1'b0 || ram_addr !== 8'd127
            || ram_wdata !== 16'd1024 || h_ack !== 1'b0) begin
            errors++;
            $display("FAIL wr_strobe: we=%b re=%b addr=%0d data=%0d ack=%b want 1 0 127 1024 0",
                     ram_we, ram_re, ram_addr, ram_wdata, h_ack);
        end
        @(negedge clk);
        checks++;
        if (h_ack !== 1'b1 || c_ack !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL wr_ack: h_ack=%b c_ack=%b we=%b want 1 0 0", h_ack, c_ack, ram_we);
        end
        h_req = 1'b0;
        @(negedge clk);
        h_req = 1'b1; h_we = 1'b0; h_addr = 8'd127;
        @(negedge clk);
        checks++;
        if (ram_re !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 8'd127) begin
            errors++;
            $display("FAIL rd_strobe: re=%b we=%b addr=%0d want 1 0 127", ram_re, ram_we, ram_addr);
        end
        @(negedge clk);
        checks++;
        if (h_ack !== 1'b1 || h_rdata !== 16'd1024) begin
            errors++;
            $display("FAIL rd_ack: h_ack=%b h_rdata=%0d want 1 1024", h_ack, h_rdata);
        end
        h_req = 1'b0;
        @(negedge clk);
        h_req = 1'b1; h_we = 1'b1; h_addr = 8'd4; h_wdata = 16'h1234;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (h_ack !== 1'b1 || h_rdata !== 16'd1024) begin
            errors++;
            $display("FAIL wr_keeps_rdata: h_ack=%b h_rdata=%0d want 1 1024", h_ack, h_rdata);
        end
        h_req = 1'b0; h_we = 1'b0;
    endtask

    task automatic test_oor;
        int nstb;
        nstb = 0;
        @(negedge clk);
        h_req = 1'b1; h_we = 1'b0; h_addr = 8'd200;
        @(negedge clk);
        if (ram_we || ram_re) nstb++;
        checks++;
        if (h_ack !== 1'b0) begin
            errors++;
            $display("FAIL oor_early_ack: h_ack=%b want 0", h_ack);
        end
        @(negedge clk);
        if (ram_we || ram_re) nstb++;
        checks++;
        if (nstb != 0) begin
            errors++;
            $display("FAIL oor_strobe: %0d strobe cycles want 0", nstb);
        end
        checks++;
        if (h_ack !== 1'b1 || h_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL oor_ack: h_ack=%b h_rdata=%h want 1 0000", h_ack, h_rdata);
        end
        h_req = 1'b0;
    endtask

    task automatic test_core_read;
        @(negedge clk);
        c_req = 1'b1; c_addr = 8'd5;
        @(negedge clk);
        checks++;
        if (ram_re !== 1'b1 || ram_addr !== 8'd5 || c_ack !== 1'b0) begin
            errors++;
            $display("FAIL core_strobe: re=%b addr=%0d c_ack=%b want 1 5 0", ram_re, ram_addr, c_ack);
        end
        @(negedge clk);
        checks++;
        if (c_ack !== 1'b1 || c_rdata !== 16'h5A5F || h_ack !== 1'b0) begin
            errors++;
            $display("FAIL core_ack: c_ack=%b c_rdata=%h h_ack=%b want 1 5a5f 0",
                     c_ack, c_rdata, h_ack);
        end
        c_req = 1'b0;
    endtask

`ifdef HWAG_REG_BOOT_EN
    task automatic test_mid_reset;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (61) @(negedge clk);
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 8'd60) begin
            errors++;
            $display("FAIL midboot_pos: we=%b addr=%0d want 1 60", ram_we, ram_addr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({ram_we, ram_re, ram_addr, ram_wdata, boot_addr, boot_done,
             h_ack, c_ack, h_rdata, c_rdata} !== '0) begin
            errors++;
            $display("FAIL midboot_reset: we=%b addr=%0d baddr=%0d done=%b want all 0",
                     ram_we, ram_addr, boot_addr, boot_done);
        end
        c_req = 1'b1; c_addr = 8'd7;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        test_boot();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (c_ack !== 1'b1 || c_rdata !== 16'h5A5D) begin
            errors++;
            $display("FAIL pending_core: c_ack=%b c_rdata=%h want 1 5a5d", c_ack, c_rdata);
        end
        c_req = 1'b0;
    endtask
`endif

    initial begin
        h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
        c_req = 1'b0; c_addr = '0;
        test_reset();
`ifdef HWAG_REG_BOOT_EN
        test_boot();
        test_contention();
        test_write_read();
        test_oor();
        test_core_read();
        test_mid_reset();
`else
        test_core_read();
        test_contention();
        test_write_read();
        test_oor();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
